i2c_bit_tx: RTL and testbench

I2C_BIT_TX -- requirements
Module: i2c_bit_tx

---
 rtl/i2c_pkg.sv | 62 ++++++
 rtl/i2c_sync2.sv | 22 ++
 rtl/i2c_bit_tx.sv | 143 ++++++++++++++
 tb/tb_i2c_bit_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit-level transmitter: command codes,
// FSM state encoding and per-phase line levels.
package i2c_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_XFER  = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START_A = 4'd1,
    ST_START_B = 4'd2,
    ST_START_C = 4'd3,
    ST_STOP_A  = 4'd4,
    ST_STOP_B  = 4'd5,
    ST_STOP_C  = 4'd6,
    ST_WR_A    = 4'd7,
    ST_WR_B    = 4'd8,
    ST_WR_C    = 4'd9,
    ST_RD_A    = 4'd10,
    ST_RD_B    = 4'd11,
    ST_RD_C    = 4'd12
  } state_t;

  // Phase sequencing inside a command; the C phase of every command returns to IDLE.
  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_START_A: next_phase = ST_START_B;
      ST_START_B: next_phase = ST_START_C;
      ST_STOP_A:  next_phase = ST_STOP_B;
      ST_STOP_B:  next_phase = ST_STOP_C;
      ST_WR_A:    next_phase = ST_WR_B;
      ST_WR_B:    next_phase = ST_WR_C;
      ST_RD_A:    next_phase = ST_RD_B;
      ST_RD_B:    next_phase = ST_RD_C;
      default:    next_phase = ST_IDLE;
    endcase
  endfunction

  // {scl_oen, sda_oen} driven while in state s (1 = released).
  function automatic logic [1:0] phase_lines(input state_t s, input logic d);
    case (s)
      ST_START_A: phase_lines = 2'b11;
      ST_START_B: phase_lines = 2'b10;
      ST_START_C: phase_lines = 2'b00;
      ST_STOP_A:  phase_lines = 2'b00;
      ST_STOP_B:  phase_lines = 2'b10;
      ST_STOP_C:  phase_lines = 2'b11;
      ST_WR_A:    phase_lines = {1'b0, d};
      ST_WR_B:    phase_lines = {1'b1, d};
      ST_WR_C:    phase_lines = {1'b0, d};
      ST_RD_A:    phase_lines = 2'b01;
      ST_RD_B:    phase_lines = 2'b11;
      ST_RD_C:    phase_lines = 2'b01;
      default:    phase_lines = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for an asynchronous bus line; idles high like a
// pulled-up open-drain wire.
module i2c_sync2 (
  input  logic clk,
  input  logic nReset,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_ff;

  // Shift the line level through two stages; both resets force the released level.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)    r_ff <= 2'b11;
    else if (i_clr) r_ff <= 2'b11;
    else            r_ff <= {r_ff[0], i_d};
  end

  assign o_q = r_ff[1];

endmodule

// File: rtl/i2c_bit_tx.sv
// I2C bit-level engine: executes START, STOP, write-bit and read-bit
// commands as three prescaled phases each, with clock stretching and
// arbitration-loss detection on write-one bits.
module i2c_bit_tx
  import i2c_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             rst,
  input  logic             ena,
  input  logic [CNT_W-1:0] clk_cnt,
  input  logic [1:0]       cmd,
  input  logic             rd,
  input  logic             din,
  input  logic             cmd_valid,
  output logic             cmd_ack,
  output logic             dout,
  output logic             busy,
  output logic             al,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oen,
  output logic             sda_oen,
  output logic             scl_o,
  output logic             sda_o
);

  logic             w_sscl, w_ssda;
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_din;
  logic [1:0]       r_age;
  logic             r_scl_hi;
  logic             r_scl_oen, r_sda_oen, r_ack, r_busy, r_al, r_dout;
  logic             w_accept, w_stretch, w_run, w_al;

  i2c_sync2 u_sync_scl (.clk(clk), .nReset(nReset), .i_clr(rst), .i_d(scl_i), .o_q(w_sscl));
  i2c_sync2 u_sync_sda (.clk(clk), .nReset(nReset), .i_clr(rst), .i_d(sda_i), .o_q(w_ssda));

  // A released SCL only counts as held low by a slave once the release has
  // had time to cross the synchronizer; r_age measures that settling window.
  assign w_stretch = r_scl_oen && (r_age == 2'd2) && !w_sscl;
  assign w_run     = ena && r_busy && !w_stretch;
  assign w_accept  = ena && cmd_valid && (cmd != CMD_NOP) && (r_state == ST_IDLE);
  // Lost arbitration: we released SDA for a one, SCL is high, yet SDA reads low.
  assign w_al      = ena && (r_state == ST_WR_B) && r_din && r_scl_hi && !w_ssda;

  // Next state: command decode out of IDLE, otherwise the phase sequence.
  always_comb begin
    w_nxt = next_phase(r_state);
    if (r_state == ST_IDLE) begin
      case (cmd)
        CMD_START: w_nxt = ST_START_A;
        CMD_STOP:  w_nxt = ST_STOP_A;
        CMD_XFER:  w_nxt = rd ? ST_RD_A : ST_WR_A;
        default:   w_nxt = ST_IDLE;
      endcase
    end
  end

  // Count cycles since SCL was released, saturating once the synchronizer has settled.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)          r_age <= 2'd0;
    else if (rst)         r_age <= 2'd0;
    else if (!r_scl_oen)  r_age <= 2'd0;
    else if (r_age != 2'd2) r_age <= r_age + 2'd1;
  end

  // Remember that SCL has been observed high during the write data-valid phase.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)                    r_scl_hi <= 1'b0;
    else if (rst)                   r_scl_hi <= 1'b0;
    else if (r_state != ST_WR_B)    r_scl_hi <= 1'b0;
    else if (w_sscl)                r_scl_hi <= 1'b1;
  end

  // Main sequencer: command accept, prescaler, phase advance, ack/al pulses.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_din     <= 1'b0;
      r_scl_oen <= 1'b1;
      r_sda_oen <= 1'b1;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_al      <= 1'b0;
      r_dout    <= 1'b0;
    end else if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_din     <= 1'b0;
      r_scl_oen <= 1'b1;
      r_sda_oen <= 1'b1;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_al      <= 1'b0;
      r_dout    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_al  <= 1'b0;
      if (w_al) begin
        r_state   <= ST_IDLE;
        r_busy    <= 1'b0;
        r_scl_oen <= 1'b1;
        r_sda_oen <= 1'b1;
        r_al      <= 1'b1;
      end else if (w_accept) begin
        r_state <= w_nxt;
        r_busy  <= 1'b1;
        r_cnt   <= clk_cnt;
        r_din   <= din;
        {r_scl_oen, r_sda_oen} <= phase_lines(w_nxt, din);
      end else if (w_run) begin
        if (r_cnt == '0) begin
          r_cnt   <= clk_cnt;
          r_state <= w_nxt;
          if (r_state == ST_RD_B) r_dout <= w_ssda;
          if (w_nxt == ST_IDLE) begin
            r_ack  <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            {r_scl_oen, r_sda_oen} <= phase_lines(w_nxt, r_din);
          end
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign cmd_ack = r_ack;
  assign dout    = r_dout;
  assign busy    = r_busy;
  assign al      = r_al;
  assign scl_oen = r_scl_oen;
  assign sda_oen = r_sda_oen;
  assign scl_o   = 1'b0;
  assign sda_o   = 1'b0;

endmodule

// File: tb/tb_i2c_bit_tx.sv
// Directed bench for i2c_bit_tx with an open-drain bus model.
module tb_i2c_bit_tx;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        nReset, rst, ena;
  logic [15:0] clk_cnt;
  logic [1:0]  cmd;
  logic        rd, din, cmd_valid;
  logic        cmd_ack, dout, busy, al;
  logic        scl_i, sda_i, scl_oen, sda_oen, scl_o, sda_o;
  logic        scl_hold, sda_low;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int n_ack = 0, n_al = 0;
  int run = 0, hi_n = 0, hi_min = 1000, hi_max = 0, sda_chg = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  always #5 clk = ~clk;

  assign scl_i = scl_oen & ~scl_hold;
  assign sda_i = sda_oen & ~sda_low;

  i2c_bit_tx #(.CNT_W(16)) dut (
    .clk(clk), .nReset(nReset), .rst(rst), .ena(ena), .clk_cnt(clk_cnt),
    .cmd(cmd), .rd(rd), .din(din), .cmd_valid(cmd_valid),
    .cmd_ack(cmd_ack), .dout(dout), .busy(busy), .al(al),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oen(scl_oen), .sda_oen(sda_oen),
    .scl_o(scl_o), .sda_o(sda_o)
  );

  always @(posedge clk) cyc++;

  // Bus monitor sampled just after each edge: pulse counts, SCL-high lengths, SDA activity under SCL high.
  always @(posedge clk) begin
    #1;
    if (cmd_ack) n_ack++;
    if (al) n_al++;
    if (scl_oen) begin
      run++;
      if (prev_scl && (sda_oen !== prev_sda)) sda_chg++;
    end else if (run > 0) begin
      hi_n++;
      if (run < hi_min) hi_min = run;
      if (run > hi_max) hi_max = run;
      run = 0;
    end
    prev_scl = scl_oen;
    prev_sda = sda_oen;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       sig = cmd_ack;
      1:       sig = sda_oen;
      2:       sig = scl_oen;
      default: sig = al;
    endcase
  endfunction

  // Wait (bounded) for a signal level at a falling edge; t = cycle stamp or -1 on timeout.
  task automatic wait_sig(input int sel, input logic val, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(sel) === val) begin
        t = cyc;
        break;
      end
    end
  endtask

  // Offer a command for one cycle; t = cycle stamp at which busy should be visible.
  task automatic issue(input logic [1:0] c, input logic r, input logic d, output int t);
    cmd = c; rd = r; din = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = cyc;
  endtask

  initial begin
    int t0, t1, t;
    int a0;
    nReset = 1'b0; rst = 1'b0; ena = 1'b1; clk_cnt = 16'd3;
    cmd = CMD_NOP; rd = 1'b0; din = 1'b0; cmd_valid = 1'b0;
    scl_hold = 1'b0; sda_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {26'd0, scl_oen, sda_oen, busy, cmd_ack, al, dout}, 32'b110000);
    nReset = 1'b1;
    repeat (3) @(negedge clk);

    // NOP is ignored
    a0 = n_ack;
    issue(CMD_NOP, 1'b0, 1'b0, t0);
    chk("nop_busy", busy, 0);
    repeat (6) @(negedge clk);
    chk("nop_ack", n_ack - a0, 0);

    // START, clk_cnt=3, with a STOP offered while busy
    a0 = n_ack;
    issue(CMD_START, 1'b0, 1'b0, t0);
    chk("start_busy", busy, 1);
    cmd = CMD_STOP; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_sig(1, 1'b0, 20, t); chk("start_sda_fall", t - t0, 4);
    wait_sig(2, 1'b0, 20, t); chk("start_scl_fall", t - t0, 8);
    wait_sig(0, 1'b1, 20, t); chk("start_ack", t - t0, 12);
    chk("start_busy_at_ack", busy, 0);
    repeat (8) @(negedge clk);
    chk("start_lines", {scl_oen, sda_oen}, 2'b00);
    chk("start_one_ack", n_ack - a0, 1);

    // Back-to-back writes din=1 then din=0
    a0 = n_ack; hi_n = 0; hi_min = 1000; hi_max = 0; sda_chg = 0;
    issue(CMD_XFER, 1'b0, 1'b1, t0);
    wait_sig(0, 1'b1, 30, t);
    chk("wr1_ack", t - t0, 12);
    issue(CMD_XFER, 1'b0, 1'b0, t1);
    chk("b2b_busy", busy, 1);
    wait_sig(0, 1'b1, 30, t);
    chk("wr0_ack", t - t1, 12);
    @(negedge clk);
    chk("wr_pulses", hi_n, 2);
    chk("wr_hi_min", hi_min, 4);
    chk("wr_hi_max", hi_max, 4);
    chk("wr_sda_stable", sda_chg, 0);
    chk("wr_lines", {scl_oen, sda_oen}, 2'b00);
    chk("wr_acks", n_ack - a0, 2);

    // Clock stretching: SCL held low for 10 cycles from the start of WR_B
    scl_hold = 1'b1;
    issue(CMD_XFER, 1'b0, 1'b0, t0);
    wait_sig(2, 1'b1, 20, t);
    repeat (10) @(negedge clk);
    scl_hold = 1'b0;
    wait_sig(0, 1'b1, 40, t);
    chk("stretch_ack", t - t0, 22);

    // ena low for 6 cycles in the middle of WR_B
    a0 = n_ack;
    issue(CMD_XFER, 1'b0, 1'b1, t0);
    repeat (5) @(negedge clk);
    ena = 1'b0;
    repeat (6) @(negedge clk);
    chk("freeze_lines", {scl_oen, sda_oen, busy}, 3'b111);
    chk("freeze_no_ack", n_ack - a0, 0);
    ena = 1'b1;
    wait_sig(0, 1'b1, 40, t);
    chk("freeze_ack", t - (t0 + 11), 7);

    // Reads, clk_cnt=2: SDA held low, then released
    clk_cnt = 16'd2;
    sda_low = 1'b1;
    issue(CMD_XFER, 1'b1, 1'b0, t0);
    wait_sig(0, 1'b1, 30, t);
    chk("rd_lat", t - t0, 9);
    chk("rd_dout0", dout, 0);
    sda_low = 1'b0;
    issue(CMD_XFER, 1'b1, 1'b0, t0);
    wait_sig(0, 1'b1, 30, t);
    chk("rd_dout1", dout, 1);

    // Arbitration loss: write one while SDA is pulled low in WR_B
    clk_cnt = 16'd3;
    a0 = n_ack;
    issue(CMD_XFER, 1'b0, 1'b1, t0);
    wait_sig(2, 1'b1, 20, t1);
    sda_low = 1'b1;
    wait_sig(3, 1'b1, 10, t);
    chk("al_time", t - t1, 4);
    chk("al_lines", {scl_oen, sda_oen, busy}, 3'b110);
    sda_low = 1'b0;
    repeat (20) @(negedge clk);
    chk("al_no_ack", n_ack - a0, 0);
    chk("al_one_pulse", n_al, 1);

    // Synchronous reset mid-write
    a0 = n_ack;
    issue(CMD_XFER, 1'b0, 1'b0, t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("srst_state", {scl_oen, sda_oen, busy, cmd_ack, al}, 5'b11000);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("srst_no_ack", n_ack - a0, 0);

    // Asynchronous reset during STOP_B
    a0 = n_ack;
    issue(CMD_STOP, 1'b0, 1'b0, t0);
    wait_sig(2, 1'b1, 20, t);
    @(negedge clk);
    nReset = 1'b0;
    #1;
    chk("arst_state", {scl_oen, sda_oen, busy, cmd_ack, al, dout}, 6'b110000);
    repeat (3) @(negedge clk);
    nReset = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_no_ack", n_ack - a0, 0);
    issue(CMD_START, 1'b0, 1'b0, t0);
    wait_sig(1, 1'b0, 20, t); chk("arst_start_sda", t - t0, 4);
    wait_sig(0, 1'b1, 20, t); chk("arst_start_ack", t - t0, 12);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
